firmware_loader_rom: RTL

Writable successor to the fixed firmware/vector ROM: holds `FIRMWARE_SIZE` bytes of firmware plus `VECTOR_COUNT` 16-bit CPU vectors and serves CPU reads exactly as the fixed ROM does. It adds a byte-stream load port, driven by the debug UART bridge, that overwrites the whole image at runtime. Loads are verified with an 8-bit checksum, and the CPU is held for the duration of a load. The block sits on the CPU bus at the firmware and vector decode regions.

---
 rtl/firmware_loader_rom.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/firmware_loader_rom.sv
// Writable firmware/vector ROM. The CPU reads it combinationally, and a byte-stream
// load port replaces the whole image. Each load is verified by an 8-bit checksum.
module firmware_loader_rom #(
    parameter int unsigned FIRMWARE_SIZE = 4096,
    parameter int unsigned VECTOR_COUNT  = 3,
    parameter int unsigned VECTOR_OFFSET = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [$clog2(FIRMWARE_SIZE)-1:0] address_i,
    input  logic                             SELECT_firmware_i,
    input  logic                             SELECT_vectors_i,
    output logic [7:0]                       data_o,
    input  logic                             load_start_i,
    input  logic                             load_valid_i,
    input  logic [7:0]                       load_data_i,
    output logic                             load_ready_o,
    output logic                             cpu_hold_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [7:0]                       checksum_o
);
    localparam int unsigned AW         = $clog2(FIRMWARE_SIZE);
    localparam int unsigned VEC_BYTES  = 2 * VECTOR_COUNT;
    localparam int unsigned IMAGE_SIZE = FIRMWARE_SIZE + VEC_BYTES;
    localparam int unsigned CW         = $clog2(IMAGE_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    logic [7:0]    r_firmware [FIRMWARE_SIZE];
    logic [7:0]    r_vectors  [8];
    state_t        r_state;
    logic [CW-1:0] r_byte_cnt;
    logic [7:0]    r_checksum;
    logic          r_load_ready;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_error;

    logic          w_handshake;
    logic          w_write;
    logic          w_is_fw;
    logic [2:0]    w_vec_wr_idx;
    logic [7:0]    w_sum;
    logic [2:0]    w_vec_rd_idx;
    logic [7:0]    w_vec_rd;
    logic [7:0]    w_fw_rd;

    assign w_handshake  = load_valid_i & r_load_ready;
    // A restart or reset in the same cycle discards the byte on the bus.
    assign w_write      = w_handshake & (r_state == S_LOAD) & ~load_start_i & ~rst_i;
    assign w_is_fw      = r_byte_cnt < CW'(FIRMWARE_SIZE);
    assign w_vec_wr_idx = 3'(r_byte_cnt - CW'(FIRMWARE_SIZE));
    assign w_sum        = r_checksum + load_data_i;

    // Image memory: not reset, keeps its last contents across reset and failed loads.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            if (w_is_fw) begin
                r_firmware[AW'(r_byte_cnt)] <= load_data_i;
            end else begin
                r_vectors[w_vec_wr_idx] <= load_data_i;
            end
        end
    end

    // CPU read path; the vector index wraps mod 8 and unused slots read as FFh.
    assign w_vec_rd_idx = 3'(address_i) - 3'(VECTOR_OFFSET);
    assign w_vec_rd     = (int'(w_vec_rd_idx) < int'(VEC_BYTES)) ? r_vectors[w_vec_rd_idx] : 8'hFF;
    assign w_fw_rd      = r_firmware[address_i];
    assign data_o       = SELECT_firmware_i ? w_fw_rd :
                          SELECT_vectors_i  ? w_vec_rd : 8'bz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_checksum   <= 8'h00;
            r_load_ready <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else if (load_start_i) begin
            // A start pulse (re)enters LOAD from every state.
            r_state      <= S_LOAD;
            r_byte_cnt   <= '0;
            r_checksum   <= 8'h00;
            r_load_ready <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_handshake) begin
                        r_checksum <= w_sum;
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                        if (r_byte_cnt == CW'(IMAGE_SIZE - 1)) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_handshake) begin
                        r_checksum   <= w_sum;
                        r_load_ready <= 1'b0;
                        r_cpu_hold   <= 1'b0;
                        if (w_sum == 8'h00) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    r_load_ready <= 1'b0;
                    r_cpu_hold   <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b0;
                    r_cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready_o = r_load_ready;
    assign cpu_hold_o   = r_cpu_hold;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign checksum_o   = r_checksum;
endmodule
